// File: rtl/hex_text_scroller.sv
// Stores a character message and scrolls it right-to-left across NUM_DIGITS seven-segment ASCII slots.
// ascii_out lags pos by one cycle; wr_ready drops once the message is complete and only clear reopens it.
module hex_text_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int ASCII_LEN  = 8,
  parameter int BUF_DEPTH  = 32,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [ASCII_LEN-1:0]                wr_char,
  input  logic                                wr_last,
  input  logic                                clear,
  input  logic                                scroll_en,
  output logic [NUM_DIGITS*ASCII_LEN-1:0]     ascii_out,
  output logic                                scrolling,
  output logic [$clog2(BUF_DEPTH+1)-1:0]      msg_len
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH + NUM_DIGITS);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW:0]            ND_W      = (PW+1)'(NUM_DIGITS);
  localparam logic [TW-1:0]          TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0]          LAST_SLOT = LW'(BUF_DEPTH - 1);
  localparam logic [ASCII_LEN-1:0]   SPACE     = ASCII_LEN'(32);
  localparam logic [NUM_DIGITS*ASCII_LEN-1:0] SPACES = {NUM_DIGITS{SPACE}};

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t                          state;
  logic [PW-1:0]                   pos;
  logic [TW-1:0]                   tick;
  logic [ASCII_LEN-1:0]            msg_buf [BUF_DEPTH];
  logic [NUM_DIGITS*ASCII_LEN-1:0] disp_nxt;
  logic [PW:0]                     vlen;
  logic                            accept;
  logic                            pos_wrap;

  assign wr_ready  = (state != SCROLL);
  assign scrolling = (state == SCROLL);
  assign accept    = wr_valid && wr_ready;
  assign vlen      = (PW+1)'(msg_len) + ND_W;
  assign pos_wrap  = ({1'b0, pos} == (vlen - 1'b1));

  // Virtual stream is NUM_DIGITS blanks followed by the message; idx < 2*vlen so one subtract wraps it.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [PW:0]   sum;
    logic [PW:0]   idx;
    logic [AW-1:0] slot;
    assign sum  = {1'b0, pos} + (PW+1)'(NUM_DIGITS - 1 - k);
    assign idx  = (sum >= vlen) ? (sum - vlen) : sum;
    assign slot = AW'(idx - ND_W);
    assign disp_nxt[k*ASCII_LEN +: ASCII_LEN] = (idx < ND_W) ? SPACE : msg_buf[slot];
  end

  always_ff @(posedge clk) begin
    if (accept && !clear)
      msg_buf[AW'(msg_len)] <= wr_char;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      msg_len   <= '0;
      pos       <= '0;
      tick      <= '0;
      ascii_out <= SPACES;
    end else if (clear) begin
      state     <= IDLE;
      msg_len   <= '0;
      pos       <= '0;
      tick      <= '0;
      ascii_out <= SPACES;
    end else begin
      case (state)
        IDLE, LOAD: begin
          ascii_out <= SPACES;
          if (accept) begin
            msg_len <= msg_len + 1'b1;
            if (wr_last || (msg_len == LAST_SLOT)) begin
              state <= SCROLL;
              pos   <= '0;
              tick  <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        SCROLL: begin
          ascii_out <= disp_nxt;
          if (scroll_en) begin
            if (tick == TICK_MAX) begin
              tick <= '0;
              pos  <= pos_wrap ? '0 : pos + 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_text_scroller.sv
// Bench for hex_text_scroller: display frames are queued with the cycle they are due and compared on the falling edge.
module tb_hex_text_scroller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_char = 8'h00;
  logic        wr_last = 1'b0;
  logic        clear = 1'b0;
  logic        scroll_en = 1'b1;
  logic [47:0] ascii_out;
  logic        scrolling;
  logic [3:0]  msg_len;

  always #5 clk = ~clk;

  hex_text_scroller #(
    .NUM_DIGITS(6), .ASCII_LEN(8), .BUF_DEPTH(8), .TICK_DIV(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .clear(clear), .scroll_en(scroll_en),
    .ascii_out(ascii_out), .scrolling(scrolling), .msg_len(msg_len)
  );

  typedef struct {
    string       tag;
    int          due;
    logic [47:0] exp;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_msg[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         e0, e1, e2;

  localparam logic [47:0] ALL_SP = 48'h202020202020;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] model(input int p);
    int v, j;
    logic [47:0] r;
    v = model_msg.size() + 6;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      j = (p + 5 - k) % v;
      r[k*8 +: 8] = (j < 6) ? 8'h20 : model_msg[j-6];
    end
    return r;
  endfunction

  task automatic push(input string tag, input int due, input logic [47:0] e);
    exp_t t;
    t.tag = tag;
    t.due = due;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, "_missed"}, 64'(cyc), 64'(mon_e.due));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.tag, 64'(ascii_out), 64'(mon_e.exp));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #3 reset_n = 1'b0;
    #1;
    check("rst_ascii", 64'(ascii_out), 64'(ALL_SP));
    check("rst_ready", 64'(wr_ready), 64'd1);
    check("rst_scroll", 64'(scrolling), 64'd0);
    check("rst_len", 64'(msg_len), 64'd0);
    reset_n = 1'b1;
    tick();

    // Load "HI".
    model_msg = '{8'h48, 8'h49};
    wr_valid = 1'b1; wr_char = 8'h48; wr_last = 1'b0;
    tick();
    check("load1_len", 64'(msg_len), 64'd1);
    check("load1_scroll", 64'(scrolling), 64'd0);
    wr_char = 8'h49; wr_last = 1'b1;
    tick();
    e0 = cyc;
    check("hi_scroll", 64'(scrolling), 64'd1);
    check("hi_len", 64'(msg_len), 64'd2);
    check("hi_ready", 64'(wr_ready), 64'd0);
    push("hi_p0", e0 + 1, ALL_SP);
    for (int p = 1; p <= 9; p++) begin
      if (p == 1)      push("hi_p1", e0 + 5, 48'h202020202048);
      else if (p == 2) push("hi_p2", e0 + 9, 48'h202020204849);
      else if (p == 8) push("hi_wrap", e0 + 33, ALL_SP);
      else             push($sformatf("hi_p%0d", p), e0 + 4*p + 1, model(p));
    end

    // Backpressure: keep offering 'A' throughout SCROLL.
    wr_char = 8'h41; wr_last = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i % 10 == 0) begin
        check("bp_ready", 64'(wr_ready), 64'd0);
        check("bp_len", 64'(msg_len), 64'd2);
      end
    end
    wr_valid = 1'b0;

    // Freeze for 20 cycles, then resume.
    scroll_en = 1'b0;
    for (int c = 41; c <= 64; c++) push("freeze", e0 + c, model(2));
    push("resume", e0 + 65, model(3));
    repeat (20) tick();
    scroll_en = 1'b1;
    repeat (5) tick();

    // Clear wins over a simultaneous write.
    clear = 1'b1; wr_valid = 1'b1; wr_char = 8'h5A; wr_last = 1'b1;
    tick();
    check("clr_len", 64'(msg_len), 64'd0);
    check("clr_scroll", 64'(scrolling), 64'd0);
    check("clr_ready", 64'(wr_ready), 64'd1);
    check("clr_ascii", 64'(ascii_out), 64'(ALL_SP));
    clear = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    tick();
    check("clr_hold_len", 64'(msg_len), 64'd0);
    check("sb_drain1", 64'(sb.size()), 64'd0);

    // Buffer full: eight characters with wr_last low.
    model_msg = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    wr_valid = 1'b1; wr_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_char = 8'h30 + 8'(i);
      tick();
      check("full_len", 64'(msg_len), 64'(i + 1));
      check("full_scroll", 64'(scrolling), 64'(i == 7));
    end
    e1 = cyc;
    wr_char = 8'h38;
    check("full_ready", 64'(wr_ready), 64'd0);
    for (int p = 0; p <= 7; p++) begin
      if (p == 6) push("full_p6", e1 + 25, 48'h303132333435);
      else        push($sformatf("full_p%0d", p), e1 + 4*p + 1, model(p));
    end
    tick();
    check("full_ninth_len", 64'(msg_len), 64'd8);
    wr_valid = 1'b0;
    repeat (30) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("full_clr_len", 64'(msg_len), 64'd0);
    check("sb_drain2", 64'(sb.size()), 64'd0);

    // Reload "HI" and reset asynchronously mid-scroll.
    model_msg = '{8'h48, 8'h49};
    wr_valid = 1'b1; wr_char = 8'h48; wr_last = 1'b0;
    tick();
    wr_char = 8'h49; wr_last = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    e2 = cyc;
    push("re_p2", e2 + 9, 48'h202020204849);
    repeat (10) tick();
    check("pre_rst_d0", 64'(ascii_out[7:0]), 64'h49);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ascii", 64'(ascii_out), 64'(ALL_SP));
    check("arst_scroll", 64'(scrolling), 64'd0);
    check("arst_ready", 64'(wr_ready), 64'd1);
    check("arst_len", 64'(msg_len), 64'd0);
    reset_n = 1'b1;
    tick();
    check("sb_drain3", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
